npu_pool_sequencer: RTL

Control sequencer that drives the NPU activation/pooling datapath (ReLU stage plus auto comparator) over a block of activations in local buffer memory. Once started, it issues buffer reads, pipelines the ReLU and comparator enables, and writes results back. Per-element ReLU mode writes every element; max-pool mode reduces each window to one value. It sits between the layer controller (start/done) and the shared ReLU/comparator instances.

---
 rtl/npu_pkg.sv | 29 ++
 rtl/npu_seq_tagpipe.sv | 52 +++++
 rtl/npu_pool_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module : npu_pkg
// Desc   : Shared FSM state, pipeline tag type and latency constants for the
//          NPU pooling sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package npu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_GAP   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FIN   = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } pipe_tag_t;

   localparam int c_rd_latency   = 1;
   localparam int c_relu_latency = 1;
   localparam int c_comp_latency = 1;

endpackage : npu_pkg
`default_nettype wire

// File: rtl/npu_seq_tagpipe.sv
`default_nettype none
// ============================================================================
// Module : npu_seq_tagpipe
// Desc   : Three-stage tag shift register that turns issued reads into ReLU,
//          comparator and write strobes.
// Rev    : 1.0  initial release
// ============================================================================
module npu_seq_tagpipe
   import npu_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      i_pool_en,
   input  pipe_tag_t i_tag,
   output logic      o_en_relu,
   output logic      o_rst_comp,
   output logic      o_en_comp,
   output logic      o_wr_en,
   output logic      o_drained
);

   pipe_tag_t r_s1;
   logic      r_s2_valid;
   logic      r_s2_last;
   logic      r_s3_wr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1       <= '0;
         r_s2_valid <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s3_wr    <= 1'b0;
      end else begin
         r_s1       <= i_tag;
         r_s2_valid <= r_s1.valid;
         r_s2_last  <= r_s1.last;
         r_s3_wr    <= r_s2_valid & r_s2_last & i_pool_en;
      end
   end

   // Drained means nothing remains that could still write after this cycle,
   // so the final write and DONE land on consecutive cycles.
   always_comb begin
      o_en_relu  = r_s1.valid;
      o_rst_comp = i_pool_en & r_s1.valid & r_s1.first;
      o_en_comp  = i_pool_en & r_s2_valid;
      o_wr_en    = i_pool_en ? r_s3_wr : r_s2_valid;
      o_drained  = i_pool_en ? !(r_s1.valid | r_s2_valid) : !r_s1.valid;
   end

endmodule : npu_seq_tagpipe
`default_nettype wire

// File: rtl/npu_pool_sequencer.sv
`default_nettype none
// ============================================================================
// Module : npu_pool_sequencer
// Desc   : Sequences buffer reads through the ReLU stage and max comparator,
//          writing element-wise ReLU results or one max per window.
// Rev    : 1.0  initial release
// ============================================================================
module npu_pool_sequencer
   import npu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int WIN_W  = 5
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [ADDR_W-1:0] CFG_BASE_ADDR,
   input  logic [ADDR_W-1:0] CFG_OUT_ADDR,
   input  logic [WIN_W-1:0]  CFG_WIN_LEN,
   input  logic [7:0]        CFG_NUM_WIN,
   input  logic              CFG_POOL_EN,
   input  logic              CFG_BYPASS,
   input  logic [DATA_W-1:0] RELU_IN,
   input  logic [DATA_W-1:0] COMP_IN,
   output logic              RD_EN,
   output logic [ADDR_W-1:0] RD_ADDR,
   output logic              En_ReLU,
   output logic              En_MAC_ReLU,
   output logic              BYPASS_ReLU,
   output logic              EN_COMP,
   output logic              RST_COMP,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [DATA_W-1:0] WR_DATA,
   output logic              BUSY,
   output logic              DONE
);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [WIN_W-1:0]  r_elem_cnt;
   logic [WIN_W-1:0]  r_win_len;
   logic [7:0]        r_win_cnt;
   logic [7:0]        r_num_win;
   logic              r_pool;
   logic              r_bypass;

   logic [WIN_W-1:0]  w_cfg_win_len;
   logic              w_accept;
   logic              w_last_elem;
   logic              w_last_win;
   pipe_tag_t         w_tag;
   logic              w_en_relu;
   logic              w_rst_comp;
   logic              w_en_comp;
   logic              w_wr_en;
   logic              w_drained;

   // ReLU mode always uses single-element windows; a zero length means one.
   assign w_cfg_win_len = (!CFG_POOL_EN || (CFG_WIN_LEN == '0)) ? WIN_W'(1) : CFG_WIN_LEN;
   assign w_accept      = (r_state == ST_IDLE) && START;
   assign w_last_elem   = (r_elem_cnt == (r_win_len - WIN_W'(1)));
   assign w_last_win    = (r_win_cnt == (r_num_win - 8'd1));

   always_comb begin
      w_tag.valid = (r_state == ST_ISSUE);
      w_tag.first = (r_elem_cnt == '0);
      w_tag.last  = w_last_elem;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_state_nxt = (CFG_NUM_WIN == 8'd0) ? ST_FIN : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_last_elem) begin
               if (w_last_win) begin
                  w_state_nxt = ST_DRAIN;
               end else if (r_pool) begin
                  w_state_nxt = ST_GAP;
               end
            end
         end
         ST_GAP:   w_state_nxt = ST_ISSUE;
         ST_DRAIN: begin
            if (w_drained) begin
               w_state_nxt = ST_FIN;
            end
         end
         ST_FIN:   w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_rd_addr  <= '0;
         r_wr_addr  <= '0;
         r_elem_cnt <= '0;
         r_win_len  <= '0;
         r_win_cnt  <= '0;
         r_num_win  <= '0;
         r_pool     <= 1'b0;
         r_bypass   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rd_addr  <= CFG_BASE_ADDR;
            r_wr_addr  <= CFG_OUT_ADDR;
            r_elem_cnt <= '0;
            r_win_len  <= w_cfg_win_len;
            r_win_cnt  <= '0;
            r_num_win  <= CFG_NUM_WIN;
            r_pool     <= CFG_POOL_EN;
            r_bypass   <= CFG_BYPASS;
         end else begin
            if (r_state == ST_ISSUE) begin
               r_rd_addr <= r_rd_addr + ADDR_W'(1);
               if (w_last_elem) begin
                  r_elem_cnt <= '0;
                  r_win_cnt  <= r_win_cnt + 8'd1;
               end else begin
                  r_elem_cnt <= r_elem_cnt + WIN_W'(1);
               end
            end
            if (w_wr_en) begin
               r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
         end
      end
   end

   npu_seq_tagpipe u_tagpipe (
      .clk        (CLK),
      .rst_n      (RST_N),
      .i_pool_en  (r_pool),
      .i_tag      (w_tag),
      .o_en_relu  (w_en_relu),
      .o_rst_comp (w_rst_comp),
      .o_en_comp  (w_en_comp),
      .o_wr_en    (w_wr_en),
      .o_drained  (w_drained)
   );

   always_comb begin
      BUSY        = (r_state != ST_IDLE);
      DONE        = (r_state == ST_FIN);
      RD_EN       = (r_state == ST_ISSUE);
      RD_ADDR     = RD_EN ? r_rd_addr : '0;
      En_ReLU     = w_en_relu;
      En_MAC_ReLU = w_en_relu;
      BYPASS_ReLU = BUSY & r_bypass;
      EN_COMP     = w_en_comp;
      RST_COMP    = w_rst_comp;
      WR_EN       = w_wr_en;
      WR_ADDR     = w_wr_en ? r_wr_addr : '0;
      WR_DATA     = w_wr_en ? (r_pool ? COMP_IN : RELU_IN) : '0;
   end

endmodule : npu_pool_sequencer
`default_nettype wire
